mano_bus_sequencer: RTL



---
 rtl/mano_bus_sequencer_if.sv | 31 +++
 rtl/mano_bus_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mano_bus_sequencer_if.sv
// Bundle of run control, IR input, execute handshake and bus-control outputs
// shared between the fetch/decode sequencer and the datapath/execute logic.
interface mano_bus_sequencer_if;
  logic        start;
  logic [15:0] ir_i;
  logic        exec_done;
  logic        halt;
  logic [7:0]  bus_sel;
  logic        ld_ar;
  logic        ld_ir;
  logic        inr_pc;
  logic        i_flag;
  logic [7:0]  d;
  logic [3:0]  sc;
  logic [15:0] t_state;
  logic        exec_req;
  logic        overrun;
  logic        halted;

  modport master (
    input  start, ir_i, exec_done, halt,
    output bus_sel, ld_ar, ld_ir, inr_pc, i_flag, d, sc, t_state,
           exec_req, overrun, halted
  );

  modport slave (
    output start, ir_i, exec_done, halt,
    input  bus_sel, ld_ar, ld_ir, inr_pc, i_flag, d, sc, t_state,
           exec_req, overrun, halted
  );
endinterface

// File: rtl/mano_bus_sequencer.sv
// Mano basic-computer fetch/decode/indirect sequencer. Owns SC and T0-T15 and
// requests bus sources; execution is delegated through exec_req/exec_done.
module mano_bus_sequencer (
  input logic                  clk,
  input logic                  rst_n,
  mano_bus_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, EXEC} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  sc_reg, sc_next;
  logic        i_flag_reg;
  logic [7:0]  d_reg, d_dec;
  logic        overrun_reg, overrun_next;
  logic        halted_reg, halted_next;
  logic [7:0]  bus_sel_c;
  logic        ld_ar_c, ld_ir_c, inr_pc_c, exec_req_c;
  logic [15:0] t_state_c;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign d_dec[gi] = (bus.ir_i[14:12] == 3'(gi));
    end
    for (genvar gi = 0; gi < 16; gi++) begin : g_tstate
      assign t_state_c[gi] = (state_reg != IDLE) && (sc_reg == 4'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      sc_reg      <= 4'd0;
      i_flag_reg  <= 1'b0;
      d_reg       <= 8'h00;
      overrun_reg <= 1'b0;
      halted_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sc_reg      <= sc_next;
      overrun_reg <= overrun_next;
      halted_reg  <= halted_next;
      if (state_reg == T2) begin
        i_flag_reg <= bus.ir_i[15];
        d_reg      <= d_dec;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    sc_next      = sc_reg;
    overrun_next = overrun_reg;
    halted_next  = halted_reg;
    bus_sel_c    = 8'h01;
    ld_ar_c      = 1'b0;
    ld_ir_c      = 1'b0;
    inr_pc_c     = 1'b0;
    exec_req_c   = 1'b0;

    case (state_reg)
      IDLE: begin
        sc_next = 4'd0;
        if (bus.start && !halted_reg) begin
          state_next   = T0;
          overrun_next = 1'b0;
        end
      end
      T0: begin
        bus_sel_c  = 8'h04;
        ld_ar_c    = 1'b1;
        state_next = T1;
        sc_next    = 4'd1;
      end
      T1: begin
        bus_sel_c  = 8'h80;
        ld_ir_c    = 1'b1;
        inr_pc_c   = 1'b1;
        state_next = T2;
        sc_next    = 4'd2;
      end
      T2: begin
        bus_sel_c  = 8'h20;
        ld_ar_c    = 1'b1;
        state_next = T3;
        sc_next    = 4'd3;
      end
      T3: begin
        // Opcode 7 is register/IO reference, so I does not mean indirect there
        if (!d_reg[7] && i_flag_reg) begin
          bus_sel_c = 8'h80;
          ld_ar_c   = 1'b1;
        end
        exec_req_c = 1'b1;
        state_next = EXEC;
        sc_next    = 4'd4;
      end
      EXEC: begin
        exec_req_c = 1'b1;
        if (sc_reg == 4'd15) overrun_next = 1'b1;
        else                 sc_next      = sc_reg + 4'd1;
      end
      default: state_next = IDLE;
    endcase

    // An accepted completion overrides the T3/EXEC progression above
    if (exec_req_c && bus.exec_done) begin
      sc_next      = 4'd0;
      overrun_next = overrun_reg;
      if (bus.halt) begin
        state_next  = IDLE;
        halted_next = 1'b1;
      end else if (bus.start) begin
        state_next   = T0;
        overrun_next = 1'b0;
      end else begin
        state_next = IDLE;
      end
    end
  end

  assign bus.bus_sel  = bus_sel_c;
  assign bus.ld_ar    = ld_ar_c;
  assign bus.ld_ir    = ld_ir_c;
  assign bus.inr_pc   = inr_pc_c;
  assign bus.i_flag   = i_flag_reg;
  assign bus.d        = d_reg;
  assign bus.sc       = sc_reg;
  assign bus.t_state  = t_state_c;
  assign bus.exec_req = exec_req_c;
  assign bus.overrun  = overrun_reg;
  assign bus.halted   = halted_reg;

endmodule
